rs_station: RTL and testbench

- Reservation station for ALU-class instructions (OP, OP-IMM, branch, JAL/JALR, LUI, AUIPC); it sits directly downstream of the decoder.
- Accepts one issued instruction per cycle when the decoder drives rs_enable.
- Holds operands pending on ROB tags and snoops the ALU and LSB-load result buses.
- Dispatches at most one operand-ready entry per cycle to the ALU.

---
 rtl/rs_station_pkg.sv | 38 +++
 rtl/rs_station_pick.sv | 31 +++
 rtl/rs_station.sv | 166 ++++++++++++++++
 tb/tb_rs_station.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_station_pkg.sv
// Shared definitions for the ALU reservation station: widths, entry record and
// the broadcast-match helper used for both snoop and issue-time forwarding.
package rs_station_pkg;

   localparam int unsigned RS_SIZE   = 16;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ROB_POS_W = 5;
   localparam int unsigned OPENUM_W  = 6;
   localparam int unsigned RS_POS_W  = $clog2(RS_SIZE);

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef logic [OPENUM_W-1:0]  openum_t;
   typedef logic [DATA_W-1:0]    data_t;
   typedef logic [DATA_W-1:0]    addr_t;
   typedef logic [ROB_POS_W-1:0] rob_pos_t;
   typedef logic [RS_POS_W-1:0]  rs_pos_t;
   typedef logic [RS_POS_W:0]    occ_t;

   typedef struct packed {
      openum_t  openum;
      data_t    rs1_val;
      rob_pos_t rs1_tag;
      data_t    rs2_val;
      rob_pos_t rs2_tag;
      data_t    imm;
      addr_t    pc;
      logic     pred_jump;
      rob_pos_t rob_pos;
   } rs_entry_t;

   // ROB position 0 means "no dependency", so it never matches a broadcast.
   function automatic logic wakes(rob_pos_t tag, logic bus_ready, rob_pos_t bus_pos);
      return (tag != '0) && bus_ready && (bus_pos == tag);
   endfunction

endpackage

// File: rtl/rs_station_pick.sv
// rs_pick: combinational dual priority encoder giving the lowest free slot and
// the lowest busy slot whose operands are both available.
module rs_pick
   import rs_station_pkg::*;
(
   input  logic [RS_SIZE-1:0] busy,
   input  logic [RS_SIZE-1:0] tags_clear,
   output rs_pos_t            free_idx,
   output logic               free_valid,
   output rs_pos_t            ready_idx,
   output logic               ready_valid
);

   always_comb begin
      free_idx    = '0;
      free_valid  = FALSE;
      ready_idx   = '0;
      ready_valid = FALSE;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!free_valid && !busy[i]) begin
            free_valid = TRUE;
            free_idx   = rs_pos_t'(i);
         end
         if (!ready_valid && busy[i] && tags_clear[i]) begin
            ready_valid = TRUE;
            ready_idx   = rs_pos_t'(i);
         end
      end
   end

endmodule

// File: rtl/rs_station.sv
// rs_station: ALU reservation station with result-bus snoop and one dispatch per cycle.
// Optional RS_STATS_EN adds dispatch and full-cycle counters.
module rs_station
   import rs_station_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 issue_valid,
   input  logic [OPENUM_W-1:0]  issue_openum,
   input  logic [DATA_W-1:0]    issue_rs1_val,
   input  logic [DATA_W-1:0]    issue_rs2_val,
   input  logic [ROB_POS_W-1:0] issue_rs1_rob_pos,
   input  logic [ROB_POS_W-1:0] issue_rs2_rob_pos,
   input  logic [DATA_W-1:0]    issue_imm,
   input  logic [DATA_W-1:0]    issue_pc,
   input  logic                 issue_pred_jump,
   input  logic [ROB_POS_W-1:0] issue_rob_pos,
   input  logic                 alu_result_ready,
   input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
   input  logic [DATA_W-1:0]    alu_result_val,
   input  logic                 lsb_load_result_ready,
   input  logic [ROB_POS_W-1:0] lsb_load_result_rob_pos,
   input  logic [DATA_W-1:0]    lsb_load_result_val,
   output logic                 rs_full,
   output logic                 alu_enable,
   output logic [OPENUM_W-1:0]  alu_openum,
   output logic [DATA_W-1:0]    alu_rs1_val,
   output logic [DATA_W-1:0]    alu_rs2_val,
   output logic [DATA_W-1:0]    alu_imm,
   output logic [DATA_W-1:0]    alu_pc,
   output logic                 alu_pred_jump,
   output logic [ROB_POS_W-1:0] alu_rob_pos
`ifdef RS_STATS_EN
   ,
   output logic [31:0]          stat_dispatch_cnt,
   output logic [31:0]          stat_full_cycles
`endif
);

   rs_entry_t          ent [RS_SIZE];
   logic [RS_SIZE-1:0] busy;
   logic [RS_SIZE-1:0] tags_clear;
   rs_pos_t            free_idx, ready_idx;
   logic               free_valid, ready_valid;
   logic               issue_take;
   occ_t               occ_cur, occ_next;
   rs_entry_t          new_ent;

   rs_pick u_pick (
      .busy        (busy),
      .tags_clear  (tags_clear),
      .free_idx    (free_idx),
      .free_valid  (free_valid),
      .ready_idx   (ready_idx),
      .ready_valid (ready_valid)
   );

   assign issue_take = issue_valid && free_valid;

   always_comb begin
      tags_clear = '0;
      occ_cur    = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         tags_clear[i] = (ent[i].rs1_tag == '0) && (ent[i].rs2_tag == '0);
         occ_cur       = occ_cur + occ_t'(busy[i]);
      end
      occ_next = occ_cur + occ_t'(issue_take) - occ_t'(ready_valid);
   end

   // Incoming operands may be satisfied by a broadcast in the issue cycle itself.
   always_comb begin
      new_ent = '{openum: issue_openum, rs1_val: issue_rs1_val, rs1_tag: issue_rs1_rob_pos,
                  rs2_val: issue_rs2_val, rs2_tag: issue_rs2_rob_pos, imm: issue_imm,
                  pc: issue_pc, pred_jump: issue_pred_jump, rob_pos: issue_rob_pos};
      if (wakes(issue_rs1_rob_pos, alu_result_ready, alu_result_rob_pos)) begin
         new_ent.rs1_val = alu_result_val;
         new_ent.rs1_tag = '0;
      end else if (wakes(issue_rs1_rob_pos, lsb_load_result_ready, lsb_load_result_rob_pos)) begin
         new_ent.rs1_val = lsb_load_result_val;
         new_ent.rs1_tag = '0;
      end
      if (wakes(issue_rs2_rob_pos, alu_result_ready, alu_result_rob_pos)) begin
         new_ent.rs2_val = alu_result_val;
         new_ent.rs2_tag = '0;
      end else if (wakes(issue_rs2_rob_pos, lsb_load_result_ready, lsb_load_result_rob_pos)) begin
         new_ent.rs2_val = lsb_load_result_val;
         new_ent.rs2_tag = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy          <= '0;
         rs_full       <= FALSE;
         alu_enable    <= FALSE;
         alu_openum    <= '0;
         alu_rs1_val   <= '0;
         alu_rs2_val   <= '0;
         alu_imm       <= '0;
         alu_pc        <= '0;
         alu_pred_jump <= FALSE;
         alu_rob_pos   <= '0;
`ifdef RS_STATS_EN
         stat_dispatch_cnt <= '0;
         stat_full_cycles  <= '0;
`endif
      end else if (rollback) begin
         busy       <= '0;
         rs_full    <= FALSE;
         alu_enable <= FALSE;
`ifdef RS_STATS_EN
         stat_dispatch_cnt <= '0;
         stat_full_cycles  <= '0;
`endif
      end else if (rdy) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy[i]) begin
               if (wakes(ent[i].rs1_tag, alu_result_ready, alu_result_rob_pos)) begin
                  ent[i].rs1_val <= alu_result_val;
                  ent[i].rs1_tag <= '0;
               end else if (wakes(ent[i].rs1_tag, lsb_load_result_ready, lsb_load_result_rob_pos)) begin
                  ent[i].rs1_val <= lsb_load_result_val;
                  ent[i].rs1_tag <= '0;
               end
               if (wakes(ent[i].rs2_tag, alu_result_ready, alu_result_rob_pos)) begin
                  ent[i].rs2_val <= alu_result_val;
                  ent[i].rs2_tag <= '0;
               end else if (wakes(ent[i].rs2_tag, lsb_load_result_ready, lsb_load_result_rob_pos)) begin
                  ent[i].rs2_val <= lsb_load_result_val;
                  ent[i].rs2_tag <= '0;
               end
            end
         end
         alu_enable <= ready_valid;
         if (ready_valid) begin
            busy[ready_idx] <= FALSE;
            alu_openum      <= ent[ready_idx].openum;
            alu_rs1_val     <= ent[ready_idx].rs1_val;
            alu_rs2_val     <= ent[ready_idx].rs2_val;
            alu_imm         <= ent[ready_idx].imm;
            alu_pc          <= ent[ready_idx].pc;
            alu_pred_jump   <= ent[ready_idx].pred_jump;
            alu_rob_pos     <= ent[ready_idx].rob_pos;
         end
         if (issue_take) begin
            ent[free_idx]  <= new_ent;
            busy[free_idx] <= TRUE;
         end
         rs_full <= (occ_next >= occ_t'(RS_SIZE - 1));
`ifdef RS_STATS_EN
         if (ready_valid) stat_dispatch_cnt <= stat_dispatch_cnt + 32'd1;
         if (rs_full)     stat_full_cycles  <= stat_full_cycles + 32'd1;
`endif
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst && !rollback && rdy && issue_valid && !free_valid)
         $display("rs_station ERROR: issue with no free slot, entry dropped (%0t)", $time);
   end
`endif

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a slot-level model.
module tb_rs_station;
   import rs_station_pkg::*;

   logic     clk, rst, rdy, rollback;
   logic     issue_valid, issue_pred_jump;
   openum_t  issue_openum;
   data_t    issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
   rob_pos_t issue_rs1_rob_pos, issue_rs2_rob_pos, issue_rob_pos;
   logic     alu_result_ready, lsb_load_result_ready;
   rob_pos_t alu_result_rob_pos, lsb_load_result_rob_pos;
   data_t    alu_result_val, lsb_load_result_val;
   logic     rs_full, alu_enable, alu_pred_jump;
   openum_t  alu_openum;
   data_t    alu_rs1_val, alu_rs2_val, alu_imm, alu_pc;
   rob_pos_t alu_rob_pos;
`ifdef RS_STATS_EN
   logic [31:0] stat_dispatch_cnt, stat_full_cycles;
`endif

   rs_station dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .issue_valid(issue_valid), .issue_openum(issue_openum),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .issue_rs1_rob_pos(issue_rs1_rob_pos), .issue_rs2_rob_pos(issue_rs2_rob_pos),
      .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
      .issue_rob_pos(issue_rob_pos),
      .alu_result_ready(alu_result_ready), .alu_result_rob_pos(alu_result_rob_pos),
      .alu_result_val(alu_result_val),
      .lsb_load_result_ready(lsb_load_result_ready),
      .lsb_load_result_rob_pos(lsb_load_result_rob_pos),
      .lsb_load_result_val(lsb_load_result_val),
      .rs_full(rs_full), .alu_enable(alu_enable), .alu_openum(alu_openum),
      .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val), .alu_imm(alu_imm),
      .alu_pc(alu_pc), .alu_pred_jump(alu_pred_jump), .alu_rob_pos(alu_rob_pos)
`ifdef RS_STATS_EN
      , .stat_dispatch_cnt(stat_dispatch_cnt), .stat_full_cycles(stat_full_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_on   = 0;

   // Reference state: which slots hold an instruction, and what each one holds.
   bit          m_busy [RS_SIZE];
   rs_entry_t   m_e    [RS_SIZE];
   bit          m_en, m_full;
   rs_entry_t   m_out;
   int unsigned m_disp, m_fullcyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit hit(rob_pos_t tag, logic v, rob_pos_t p);
      return v && tag != 0 && tag == p;
   endfunction

   function automatic rs_entry_t capture(rs_entry_t e);
      if (hit(e.rs1_tag, alu_result_ready, alu_result_rob_pos)) begin
         e.rs1_val = alu_result_val; e.rs1_tag = 0;
      end else if (hit(e.rs1_tag, lsb_load_result_ready, lsb_load_result_rob_pos)) begin
         e.rs1_val = lsb_load_result_val; e.rs1_tag = 0;
      end
      if (hit(e.rs2_tag, alu_result_ready, alu_result_rob_pos)) begin
         e.rs2_val = alu_result_val; e.rs2_tag = 0;
      end else if (hit(e.rs2_tag, lsb_load_result_ready, lsb_load_result_rob_pos)) begin
         e.rs2_val = lsb_load_result_val; e.rs2_tag = 0;
      end
      return e;
   endfunction

   task automatic model_step();
      int sel, fr, occ;
      rs_entry_t ne;
      sel = -1; fr = -1; occ = 0;
      if (!rst) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_en = 0; m_full = 0; m_out = '0; m_disp = 0; m_fullcyc = 0;
      end else if (rollback) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_en = 0; m_full = 0; m_disp = 0; m_fullcyc = 0;
      end else if (rdy) begin
         if (m_full) m_fullcyc++;
         foreach (m_busy[i]) begin
            if (sel < 0 && m_busy[i] && m_e[i].rs1_tag == 0 && m_e[i].rs2_tag == 0) sel = i;
            if (fr < 0 && !m_busy[i]) fr = i;
         end
         foreach (m_busy[i]) if (m_busy[i]) m_e[i] = capture(m_e[i]);
         m_en = (sel >= 0);
         if (sel >= 0) begin
            m_out = m_e[sel]; m_busy[sel] = 0; m_disp++;
         end
         if (issue_valid && fr >= 0) begin
            ne = '{openum: issue_openum, rs1_val: issue_rs1_val, rs1_tag: issue_rs1_rob_pos,
                   rs2_val: issue_rs2_val, rs2_tag: issue_rs2_rob_pos, imm: issue_imm,
                   pc: issue_pc, pred_jump: issue_pred_jump, rob_pos: issue_rob_pos};
            m_e[fr] = capture(ne); m_busy[fr] = 1;
         end
         foreach (m_busy[i]) occ += int'(m_busy[i]);
         m_full = (occ >= RS_SIZE - 1);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("alu_enable", 64'(alu_enable), 64'(m_en));
         chk("rs_full", 64'(rs_full), 64'(m_full));
         chk("alu_openum", 64'(alu_openum), 64'(m_out.openum));
         chk("alu_rs1_val", 64'(alu_rs1_val), 64'(m_out.rs1_val));
         chk("alu_rs2_val", 64'(alu_rs2_val), 64'(m_out.rs2_val));
         chk("alu_imm", 64'(alu_imm), 64'(m_out.imm));
         chk("alu_pc", 64'(alu_pc), 64'(m_out.pc));
         chk("alu_pred_jump", 64'(alu_pred_jump), 64'(m_out.pred_jump));
         chk("alu_rob_pos", 64'(alu_rob_pos), 64'(m_out.rob_pos));
`ifdef RS_STATS_EN
         chk("stat_dispatch_cnt", 64'(stat_dispatch_cnt), 64'(m_disp));
         chk("stat_full_cycles", 64'(stat_full_cycles), 64'(m_fullcyc));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; alu_result_ready = 0; lsb_load_result_ready = 0; rollback = 0;
   endtask

   task automatic issue(input int op, input int v1, input int t1, input int v2, input int t2,
                        input int rp);
      issue_valid = 1; issue_openum = openum_t'(op);
      issue_rs1_val = data_t'(v1); issue_rs1_rob_pos = rob_pos_t'(t1);
      issue_rs2_val = data_t'(v2); issue_rs2_rob_pos = rob_pos_t'(t2);
      issue_imm = data_t'(op * 16 + rp); issue_pc = data_t'(32'h1000 + rp * 4);
      issue_pred_jump = rp[0]; issue_rob_pos = rob_pos_t'(rp);
   endtask

   task automatic bcast_alu(input int p, input int v);
      alu_result_ready = 1; alu_result_rob_pos = rob_pos_t'(p); alu_result_val = data_t'(v);
   endtask

   initial begin
      rst = 0; rdy = 1; idle();
      issue(0, 0, 0, 0, 0, 0); issue_valid = 0;
      alu_result_rob_pos = 0; alu_result_val = 0;
      lsb_load_result_rob_pos = 0; lsb_load_result_val = 0;
      tick(); chk_on = 1; tick();
      chk("reset_alu_enable", 64'(alu_enable), 64'd0);
      chk("reset_rs_full", 64'(rs_full), 64'd0);
      chk("reset_alu_rs1_val", 64'(alu_rs1_val), 64'd0);
      rst = 1;

      // Ready-at-issue instruction dispatches one cycle after being written.
      issue(1, 5, 0, 7, 0, 3); tick(); idle();
      chk("t1_not_yet", 64'(alu_enable), 64'd0);
      tick();
      chk("t1_enable", 64'(alu_enable), 64'd1);
      chk("t1_rs1", 64'(alu_rs1_val), 64'd5);
      chk("t1_rs2", 64'(alu_rs2_val), 64'd7);
      chk("t1_rob_pos", 64'(alu_rob_pos), 64'd3);
      tick();
      chk("t1_pulse_end", 64'(alu_enable), 64'd0);

      // Wake via ALU broadcast two cycles after issue.
      issue(2, 0, 4, 9, 0, 8); tick(); idle(); tick();
      bcast_alu(4, 32'h10); tick(); idle();
      chk("t2_wait", 64'(alu_enable), 64'd0);
      tick();
      chk("t2_enable", 64'(alu_enable), 64'd1);
      chk("t2_rs1", 64'(alu_rs1_val), 64'h10);
      chk("t2_rs2", 64'(alu_rs2_val), 64'd9);

      // Same-cycle forwarding from the load bus at issue.
      issue(3, 0, 0, 0, 6, 9);
      lsb_load_result_ready = 1; lsb_load_result_rob_pos = 6; lsb_load_result_val = 32'hFF;
      tick(); idle(); tick();
      chk("t3_enable", 64'(alu_enable), 64'd1);
      chk("t3_rs2", 64'(alu_rs2_val), 64'hFF);
      tick();

      // Fill 15 dependent entries; rs_full asserts exactly after the 15th.
      for (int k = 0; k < 15; k++) begin
         issue(4, 0, k + 1, 0, 0, k + 1); tick();
         if (k == 13) chk("fill14_full", 64'(rs_full), 64'd0);
      end
      idle();
      chk("fill15_full", 64'(rs_full), 64'd1);
      bcast_alu(1, 32'h55); tick(); idle();
      chk("wake_full_held", 64'(rs_full), 64'd1);
      tick();
      chk("wake_enable", 64'(alu_enable), 64'd1);
      chk("wake_rs1", 64'(alu_rs1_val), 64'h55);
      chk("wake_full_drop", 64'(rs_full), 64'd0);

      // Rollback with a simultaneous issue clears everything.
      rollback = 1; tick(); idle();
      for (int k = 0; k < 8; k++) begin
         issue(5, 0, 0, 0, 20 + k, 16 + k); tick();
      end
      issue(6, 1, 0, 2, 0, 30); rollback = 1; tick(); idle();
      chk("rb_full", 64'(rs_full), 64'd0);
      for (int k = 0; k < 3; k++) begin
         chk("rb_no_enable", 64'(alu_enable), 64'd0);
         tick();
      end

      // rdy low freezes dispatch and snoop.
      issue(7, 0, 9, 3, 0, 13); tick();
      issue(7, 32'h11, 0, 32'h22, 0, 12); tick(); idle();
      rdy = 0; bcast_alu(9, 32'h99);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("frz_no_enable", 64'(alu_enable), 64'd0);
      end
      rdy = 1; idle(); tick();
      chk("resume_enable", 64'(alu_enable), 64'd1);
      chk("resume_rs1", 64'(alu_rs1_val), 64'h11);
      tick();
      chk("frz_no_capture", 64'(alu_enable), 64'd0);
      bcast_alu(9, 32'h99); tick(); idle(); tick();
      chk("late_wake_enable", 64'(alu_enable), 64'd1);
      chk("late_wake_rs1", 64'(alu_rs1_val), 64'h99);

      // Reset in the cycle a dispatch would happen.
      issue(8, 1, 0, 1, 0, 2); tick(); idle(); rst = 0; tick();
      chk("rst_mid_enable", 64'(alu_enable), 64'd0);
      chk("rst_mid_rob_pos", 64'(alu_rob_pos), 64'd0);
      rst = 1;

      for (int n = 0; n < 3000; n++) begin
         rdy      = ($urandom_range(0, 7) != 0);
         rollback = ($urandom_range(0, 63) == 0);
         rst      = ($urandom_range(0, 499) != 0);
         issue($urandom_range(0, 63), $urandom, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7),
               $urandom, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 31));
         issue_valid = rdy && !m_full && ($urandom_range(0, 3) != 0);
         alu_result_ready = $urandom_range(0, 1) == 1;
         alu_result_rob_pos = rob_pos_t'($urandom_range(0, 7));
         alu_result_val = $urandom;
         lsb_load_result_ready = $urandom_range(0, 1) == 1;
         lsb_load_result_rob_pos = rob_pos_t'($urandom_range(0, 7));
         lsb_load_result_val = $urandom;
         tick();
      end
      rst = 1; rdy = 1; idle(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
